pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline-stage register with a valid/ready handshake, an optional two-entry skid buffer, stall hold, and flush with bubble (NOP) insertion. It generalises the fixed-width IF/ID latch into one reusable stage for IF/ID, ID/EX, EX/MEM and MEM/WB. It also adds backpressure that does not depend on a combinational ready path, and a saturating count of beats discarded by flush. One instance sits between each pair of CPU pipeline stages.

## Interface
- `DATA_W`, default 64: payload width (e.g. instr + pc4).
- `NOP_VALUE`, default `'0`: payload presented on `out_data` when the stage holds no beat.
- `SKID`, default 1: 1 = two-entry buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.
- `CNT_W`, default 8: width of `drop_cnt`.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream beat present.
- `in_ready` output 1: stage accepts a beat this cycle.
- `in_data` input DATA_W: upstream payload.
- `out_valid` output 1: beat presented downstream.
- `out_ready` input 1: downstream accepts.
- `out_data` output DATA_W: downstream payload.
- `stall` input 1: hazard hold; treated as `out_ready`=0.
- `flush` input 1: discard all held beats and this cycle's input.
- `occupancy` output 2: entries held (0..2).
- `drop_cnt` output CNT_W: saturating count of beats discarded by flush.

## Operation
- push = `in_valid` & `in_ready` & !`flush`.
- pop = `out_valid` & `out_ready` & !`stall`.
- States (SKID=1):
  - EMPTY -> ONE on push (main<=in).
  - ONE -> TWO on push & !pop (skid<=in).
  - ONE -> EMPTY on pop & !push.
  - ONE stays ONE on push & pop (main<=in).
  - TWO -> ONE on pop (main<=skid). No push is possible in TWO.
- SKID=0: states EMPTY/ONE only. `in_ready` = !`out_valid` | (`out_ready` & !`stall`), combinational.
- Outputs:
  - `out_valid` = state != EMPTY.
  - `out_data` = main in ONE/TWO; `NOP_VALUE` in EMPTY.
  - `in_ready` (SKID=1) = state != TWO, decoded from the state register only.
  - `occupancy` = 0/1/2 for EMPTY/ONE/TWO.
- Flush:
  - Next state is EMPTY and both entries are cleared to `NOP_VALUE`.
  - Beats discarded = `occupancy`, plus 1 if `in_valid` & `in_ready` that cycle.
  - `drop_cnt` += that amount, saturating at 2^CNT_W−1.
- Priority: `reset` > `flush` > `stall`/handshake. A pop in a flush cycle is still a transfer downstream and is not counted as dropped.
- Reset: state EMPTY, main/skid = `NOP_VALUE`, `drop_cnt` = 0.

## Timing
- Latency: a beat pushed at edge N is visible on `out_data` after edge N (one cycle).
- Throughput: 1 beat/cycle with `out_ready`=1 and `stall`=0.
- SKID=1 has no combinational path from `out_ready`/`stall` to `in_ready`.
- After reset: `out_valid`=0, `in_ready`=1, `out_data`=`NOP_VALUE`, `occupancy`=0, `drop_cnt`=0.
- Flush:
  - The cycle after flush shows `out_valid`=0 and `out_data`=`NOP_VALUE`.
  - `in_ready`=1 in that cycle, because flush forces EMPTY.
- `stall` held for many cycles: state and data are frozen, and SKID=1 absorbs exactly one extra beat.
- Data stability: `out_data` is stable while `out_valid` & !pop. Upstream must hold `in_data` while `in_valid` & !`in_ready`.
- `drop_cnt` updates on the same edge that performs the flush.

## Structure
- Package `pipe_pkg`:
  - typedef enum `pipe_state_e` {PS_EMPTY, PS_ONE, PS_TWO}.
  - Function `occ_of(pipe_state_e)`.
- Sub-module `sat_counter` (params W, max increment 3; ports `clk`, `reset`, `inc`[1:0], `count`) implements `drop_cnt`.
- The remainder is one always_ff for state/main/skid plus combinational output decode. SKID=0 is selected with a generate branch.

## Test plan
- Reset mid-stream: occupancy 2, assert `reset` -> next cycle `out_valid`=0, `out_data`=0, `in_ready`=1, `drop_cnt`=0.
- Streaming: push 0x11, 0x22, 0x33 with `out_ready`=1 -> outputs 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after its push, occupancy ≤1.
- Backpressure (SKID=1): `stall`=1, push 0xA then 0xB -> occupancy 2 and `in_ready`=0. Release `stall` -> output 0xA then 0xB, with no loss or duplication.
- Flush with input: occupancy 2, `in_valid`=1, flush=1 -> occupancy 0, `out_data`=`NOP_VALUE`, `drop_cnt`=2 (`in_ready` was 0). Repeat at occupancy 1 with `in_valid`=1 -> `drop_cnt`=4.
- Saturation: CNT_W=2, three flushes at occupancy 2 -> `drop_cnt` sticks at 3.
- SKID=0: `out_ready` toggling 1,0,1 with continuous `in_valid` -> `in_ready` follows `out_ready` in the same cycle, and every accepted beat appears exactly once.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage buffer: occupancy state encoding and decode helper.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } pipe_state_e;

   function automatic logic [1:0] occ_of(input pipe_state_e s);
      logic [1:0] occ;
      case (s)
         PS_ONE:  occ = 2'd1;
         PS_TWO:  occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a 0..3 increment per cycle; sticks at all-ones.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   inc,
   output logic [W-1:0] count
);

   localparam logic [W+1:0] MaxCount = {2'b00, {W{1'b1}}};

   logic [W+1:0] sum;
   logic [W-1:0] count_d;

   assign sum = {2'b00, count} + {{W{1'b0}}, inc};

   always_comb begin
      count_d = sum[W-1:0];
      if (sum > MaxCount) begin
         count_d = MaxCount[W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= count_d;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Reusable CPU pipeline-stage register: valid/ready handshake, optional 2-entry skid,
// stall hold, and flush that inserts a NOP bubble and counts discarded beats.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int unsigned          DATA_W    = 64,
   parameter logic [DATA_W-1:0]    NOP_VALUE = '0,
   parameter int unsigned          SKID      = 1,
   parameter int unsigned          CNT_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              stall,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  drop_cnt
);

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              accept, push, pop;
   logic [1:0]        drop_inc;

   assign out_valid = (state_q != PS_EMPTY);
   assign out_data  = out_valid ? main_q : NOP_VALUE;
   assign occupancy = occ_of(state_q);

   generate
      if (SKID != 0) begin : g_skid
         // Registered ready: depends only on state, never on out_ready/stall.
         assign in_ready = (state_q != PS_TWO);
      end else begin : g_no_skid
         assign in_ready = !out_valid || (out_ready && !stall);
      end
   endgenerate

   assign accept = in_valid && in_ready;
   assign push   = accept && !flush;
   assign pop    = out_valid && out_ready && !stall;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = PS_EMPTY;
         main_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end else begin
         unique case (state_q)
            PS_EMPTY: begin
               if (push) begin
                  state_d = PS_ONE;
                  main_d  = in_data;
               end
            end
            PS_ONE: begin
               if (push && pop) begin
                  main_d = in_data;
               end else if (push) begin
                  state_d = PS_TWO;
                  skid_d  = in_data;
               end else if (pop) begin
                  state_d = PS_EMPTY;
               end
            end
            PS_TWO: begin
               if (pop) begin
                  state_d = PS_ONE;
                  main_d  = skid_q;
                  skid_d  = NOP_VALUE;
               end
            end
            default: state_d = PS_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= PS_EMPTY;
         main_q  <= NOP_VALUE;
         skid_q  <= NOP_VALUE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // A beat popped during flush still went downstream, so it is not a drop.
   always_comb begin
      drop_inc = 2'd0;
      if (flush) begin
         drop_inc = occupancy + {1'b0, accept} - {1'b0, pop};
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_drop_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (drop_inc),
      .count (drop_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: skid instance, CNT_W=2 saturation instance sharing its inputs,
// and a SKID=0 instance, with in-order scoreboards on every downstream transfer.
module tb_pipe_stage_buf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Shared stimulus for the skid instance and the saturation instance.
   logic       reset = 1'b1;
   logic       in_valid = 1'b0, out_ready = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, out_valid;
   logic [7:0] out_data;
   logic [1:0] occupancy;
   logic [7:0] drop_cnt;

   logic       s_in_ready, s_out_valid;
   logic [7:0] s_out_data;
   logic [1:0] s_occupancy;
   logic [1:0] s_drop_cnt;

   logic       z_in_valid = 1'b0, z_out_ready = 1'b0;
   logic [7:0] z_in_data = '0;
   logic       z_in_ready, z_out_valid;
   logic [7:0] z_out_data;
   logic [1:0] z_occupancy;
   logic [3:0] z_drop_cnt;

   pipe_stage_buf #(.DATA_W(8), .NOP_VALUE(8'h00), .SKID(1), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .stall(stall),
      .flush(flush), .occupancy(occupancy), .drop_cnt(drop_cnt)
   );

   pipe_stage_buf #(.DATA_W(8), .NOP_VALUE(8'h00), .SKID(1), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .stall(stall),
      .flush(flush), .occupancy(s_occupancy), .drop_cnt(s_drop_cnt)
   );

   pipe_stage_buf #(.DATA_W(8), .NOP_VALUE(8'hEE), .SKID(0), .CNT_W(4)) dut_z (
      .clk(clk), .reset(reset), .in_valid(z_in_valid), .in_ready(z_in_ready),
      .in_data(z_in_data), .out_valid(z_out_valid), .out_ready(z_out_ready),
      .out_data(z_out_data), .stall(1'b0), .flush(1'b0), .occupancy(z_occupancy),
      .drop_cnt(z_drop_cnt)
   );

   logic [7:0] sb_q[$];
   logic [7:0] zq[$];
   logic [7:0] sb_exp, z_exp;

   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready && !stall) begin
            if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else begin
               sb_exp = sb_q.pop_front();
               check("sb_data", {24'd0, out_data}, {24'd0, sb_exp});
            end
         end
         if (flush) sb_q.delete();
         else if (in_valid && in_ready) sb_q.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         zq.delete();
      end else begin
         if (z_out_valid) check("z_ready_follows", {31'd0, z_in_ready}, {31'd0, z_out_ready});
         if (z_out_valid && z_out_ready) begin
            if (zq.size() == 0) check("z_underflow", 32'd1, 32'd0);
            else begin
               z_exp = zq.pop_front();
               check("z_data", {24'd0, z_out_data}, {24'd0, z_exp});
            end
         end
         if (z_in_valid && z_in_ready) zq.push_back(z_in_data);
      end
   end

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_data"}, {24'd0, out_data}, 32'h00);
      check({tag, "_occ"}, {30'd0, occupancy}, 32'd0);
   endtask

   logic       acc;
   logic [9:0] pat;

   initial begin
      cyc(2);
      reset = 1'b0;
      check_idle("rst");
      check("rst_drop", {24'd0, drop_cnt}, 32'd0);
      check("z_rst_data", {24'd0, z_out_data}, 32'hEE);

      // Streaming
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h11; cyc(); check("st_d1", {24'd0, out_data}, 32'h11);
      check("st_occ1", {30'd0, occupancy}, 32'd1);
      in_data = 8'h22; cyc(); check("st_d2", {24'd0, out_data}, 32'h22);
      in_data = 8'h33; cyc(); check("st_d3", {24'd0, out_data}, 32'h33);
      check("st_occ3", {30'd0, occupancy}, 32'd1);
      in_valid = 1'b0; cyc(); check_idle("st_end");

      // Backpressure via stall
      stall = 1'b1; in_valid = 1'b1;
      in_data = 8'h0A; cyc(); check("bp_occ1", {30'd0, occupancy}, 32'd1);
      in_data = 8'h0B; cyc(); check("bp_occ2", {30'd0, occupancy}, 32'd2);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      in_data = 8'h0C; cyc(3);
      check("bp_hold_d", {24'd0, out_data}, 32'h0A);
      check("bp_hold_occ", {30'd0, occupancy}, 32'd2);
      stall = 1'b0; cyc();
      check("bp_rel_b", {24'd0, out_data}, 32'h0B);
      check("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
      cyc(); check("bp_rel_c", {24'd0, out_data}, 32'h0C);
      in_valid = 1'b0; cyc(); check("bp_end_occ", {30'd0, occupancy}, 32'd0);

      // Flush at occupancy 2 with input (input not accepted)
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'h44; cyc();
      in_data = 8'h55; cyc();
      in_data = 8'h66; flush = 1'b1; cyc();
      flush = 1'b0; in_valid = 1'b0;
      check_idle("fl1");
      check("fl1_drop", {24'd0, drop_cnt}, 32'd2);
      check("fl1_sat", {30'd0, s_drop_cnt}, 32'd2);

      // Flush at occupancy 1 with accepted input
      in_valid = 1'b1; in_data = 8'h77; cyc();
      in_data = 8'h88; flush = 1'b1; cyc();
      flush = 1'b0; in_valid = 1'b0;
      check_idle("fl2");
      check("fl2_drop", {24'd0, drop_cnt}, 32'd4);
      check("fl2_sat", {30'd0, s_drop_cnt}, 32'd3);

      // Third flush at occupancy 2: saturating counter sticks
      in_valid = 1'b1; in_data = 8'h99; cyc();
      in_data = 8'hAA; cyc();
      in_data = 8'hAB; flush = 1'b1; cyc();
      flush = 1'b0; in_valid = 1'b0;
      check("fl3_drop", {24'd0, drop_cnt}, 32'd6);
      check("fl3_sat", {30'd0, s_drop_cnt}, 32'd3);

      // Flush coinciding with a pop: popped beat is not a drop
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hBB; cyc();
      in_valid = 1'b0; flush = 1'b1; cyc();
      flush = 1'b0;
      check_idle("fl4");
      check("fl4_drop", {24'd0, drop_cnt}, 32'd6);

      // Reset mid-stream
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'hC1; cyc();
      in_data = 8'hC2; cyc();
      check("mr_occ", {30'd0, occupancy}, 32'd2);
      reset = 1'b1; in_valid = 1'b0; cyc();
      reset = 1'b0;
      check_idle("mr");
      check("mr_drop", {24'd0, drop_cnt}, 32'd0);
      check("mr_sat", {30'd0, s_drop_cnt}, 32'd0);

      // SKID=0: toggling out_ready with continuous in_valid
      pat = 10'b1101001101;
      z_in_valid = 1'b1; z_in_data = 8'h01;
      for (int i = 0; i < 10; i++) begin
         z_out_ready = pat[i];
         @(negedge clk);
         acc = z_in_valid && z_in_ready;
         @(posedge clk);
         #1;
         if (acc) z_in_data = z_in_data + 8'd1;
      end
      z_in_valid = 1'b0; z_out_ready = 1'b1; cyc(2);
      check("z_drain_valid", {31'd0, z_out_valid}, 32'd0);
      check("z_drain_data", {24'd0, z_out_data}, 32'hEE);
      check("z_accepted", {24'd0, z_in_data}, 32'h07);
      check("z_sb_empty", zq.size(), 32'd0);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
